// File: rtl/pipe_stage_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_tracker_pkg
//  Purpose  : Shared constants and payload types for the MIPS pipeline
//             stage tracker: NOP encoding, LW/SW opcodes, stage indices and
//             the packed per-stage payload layouts.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_stage_tracker_pkg;

    // All-zero word is sll $0,$0,0, used as the bubble instruction.
    localparam logic [31:0] c_inst_nop = 32'h0000_0000;

    // Primary opcodes of the memory instructions.
    localparam logic [5:0]  c_inst_lw  = 6'b100011;
    localparam logic [5:0]  c_inst_sw  = 6'b101011;

    // Stage indices, IF nearest to fetch.
    localparam int unsigned c_stage_if  = 0;
    localparam int unsigned c_stage_id  = 1;
    localparam int unsigned c_stage_exe = 2;
    localparam int unsigned c_stage_mem = 3;
    localparam int unsigned c_stage_wb  = 4;

    // Payload carried through EXE and MEM.
    typedef struct packed {
        logic [31:0] inst;
        logic [4:0]  regw_addr;
        logic        wb_wen;
        logic        is_branch;
        logic        is_load;
    } exe_payload_t;

    // WB only needs the register-write information.
    typedef struct packed {
        logic [4:0]  regw_addr;
        logic        wb_wen;
    } wb_payload_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Generic valid + payload pipeline register. Priority:
//             async reset > stage reset (bubble) > enable (capture) > hold.
//             A bubble clears the payload to all zeros, which is the NOP
//             encoding for instruction payloads.
//  Ports    : clk, rst_n          clock, asynchronous active-low reset
//             i_stage_rst        synchronous bubble insertion
//             i_stage_en         advance enable
//             i_valid, i_data    upstream valid flag and payload
//             o_valid, o_data    registered valid flag and payload
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_stage_rst,
    input  logic             i_stage_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_stage_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_stage_en) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_tracker
//  Purpose  : Datapath-side responder for the 5-stage MIPS pipeline
//             controller. Carries per-instruction control metadata through
//             ID/EXE/MEM/WB, reports stage-valid flags and valid-gated
//             hazard feedback, and pulses retire when WB drains.
//  Config   : PIPE_PERF_CNT_EN - adds perf_clr and the cycle/retire/stall/
//             flush counter bank; absent otherwise.
//  Ports    : clk, rst_n                      clock, async active-low reset
//             *_rst, *_en                     per-stage bubble / advance
//             inst_if                         fetched instruction
//             id_regw_addr/wb_wen/is_branch/mem_ren  ID decode results
//             *_valid                         stage holds real instruction
//             inst_id, inst_data_exe/mem      stage instructions
//             regw_addr_*, wb_wen_*, is_branch_*, is_load_*  gated feedback
//             retire                          instruction leaves WB
//             perf_clr, cnt_*                 counters (optional)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_tracker
    import pipe_stage_tracker_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_rst,
    input  logic        id_rst,
    input  logic        exe_rst,
    input  logic        mem_rst,
    input  logic        wb_rst,
    input  logic        if_en,
    input  logic        id_en,
    input  logic        exe_en,
    input  logic        mem_en,
    input  logic        wb_en,
    input  logic [31:0] inst_if,
    input  logic [4:0]  id_regw_addr,
    input  logic        id_wb_wen,
    input  logic        id_is_branch,
    input  logic        id_mem_ren,
    output logic        if_valid,
    output logic        id_valid,
    output logic        exe_valid,
    output logic        mem_valid,
    output logic        wb_valid,
    output logic [31:0] inst_id,
    output logic [31:0] inst_data_exe,
    output logic [31:0] inst_data_mem,
    output logic [4:0]  regw_addr_exe,
    output logic [4:0]  regw_addr_mem,
    output logic [4:0]  regw_addr_wb,
    output logic        wb_wen_exe,
    output logic        wb_wen_mem,
    output logic        wb_wen_wb,
    output logic        is_branch_exe,
    output logic        is_branch_mem,
    output logic        is_load_exe,
    output logic        is_load_mem,
    output logic        retire
`ifdef PIPE_PERF_CNT_EN
    ,
    input  logic        perf_clr,
    output logic [31:0] cnt_cycle,
    output logic [31:0] cnt_retire,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_flush
`endif
);

    logic         r_if_valid;
    logic         w_id_valid;
    logic [31:0]  w_id_inst;
    logic         w_exe_valid;
    logic         w_mem_valid;
    logic         w_wb_valid;
    exe_payload_t w_exe_in;
    exe_payload_t w_exe_q;
    exe_payload_t w_mem_q;
    wb_payload_t  w_wb_in;
    wb_payload_t  w_wb_q;

    // IF has no payload of its own: the instruction arrives on inst_if.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
        end else if (if_rst) begin
            r_if_valid <= 1'b0;
        end else if (if_en) begin
            r_if_valid <= 1'b1;
        end
    end

    pipe_stage_reg #(.WIDTH(32)) u_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stage_rst (id_rst),
        .i_stage_en  (id_en),
        .i_valid     (r_if_valid),
        .i_data      (inst_if),
        .o_valid     (w_id_valid),
        .o_data      (w_id_inst)
    );

    // Decode results belong to the instruction currently in ID.
    assign w_exe_in = '{inst:      w_id_inst,
                        regw_addr: id_regw_addr,
                        wb_wen:    id_wb_wen,
                        is_branch: id_is_branch,
                        is_load:   id_mem_ren};

    pipe_stage_reg #(.WIDTH($bits(exe_payload_t))) u_exe (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stage_rst (exe_rst),
        .i_stage_en  (exe_en),
        .i_valid     (w_id_valid),
        .i_data      (w_exe_in),
        .o_valid     (w_exe_valid),
        .o_data      (w_exe_q)
    );

    pipe_stage_reg #(.WIDTH($bits(exe_payload_t))) u_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stage_rst (mem_rst),
        .i_stage_en  (mem_en),
        .i_valid     (w_exe_valid),
        .i_data      (w_exe_q),
        .o_valid     (w_mem_valid),
        .o_data      (w_mem_q)
    );

    assign w_wb_in = '{regw_addr: w_mem_q.regw_addr, wb_wen: w_mem_q.wb_wen};

    pipe_stage_reg #(.WIDTH($bits(wb_payload_t))) u_wb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stage_rst (wb_rst),
        .i_stage_en  (wb_en),
        .i_valid     (w_mem_valid),
        .i_data      (w_wb_in),
        .o_valid     (w_wb_valid),
        .o_data      (w_wb_q)
    );

    assign if_valid      = r_if_valid;
    assign id_valid      = w_id_valid;
    assign exe_valid     = w_exe_valid;
    assign mem_valid     = w_mem_valid;
    assign wb_valid      = w_wb_valid;

    assign inst_id       = w_id_inst;
    assign inst_data_exe = w_exe_q.inst;
    assign inst_data_mem = w_mem_q.inst;

    // Gate with valid so a held-but-invalidated payload never leaks out.
    assign regw_addr_exe = w_exe_valid ? w_exe_q.regw_addr : 5'd0;
    assign regw_addr_mem = w_mem_valid ? w_mem_q.regw_addr : 5'd0;
    assign regw_addr_wb  = w_wb_valid  ? w_wb_q.regw_addr  : 5'd0;
    assign wb_wen_exe    = w_exe_valid & w_exe_q.wb_wen;
    assign wb_wen_mem    = w_mem_valid & w_mem_q.wb_wen;
    assign wb_wen_wb     = w_wb_valid  & w_wb_q.wb_wen;
    assign is_branch_exe = w_exe_valid & w_exe_q.is_branch;
    assign is_branch_mem = w_mem_valid & w_mem_q.is_branch;
    assign is_load_exe   = w_exe_valid & w_exe_q.is_load;
    assign is_load_mem   = w_mem_valid & w_mem_q.is_load;

    assign retire        = w_wb_valid & wb_en & ~wb_rst;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_cnt_cycle;
    logic [31:0] r_cnt_retire;
    logic [31:0] r_cnt_stall;
    logic [31:0] r_cnt_flush;

    // Clear outranks every increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_cycle  <= 32'd0;
            r_cnt_retire <= 32'd0;
            r_cnt_stall  <= 32'd0;
            r_cnt_flush  <= 32'd0;
        end else if (perf_clr) begin
            r_cnt_cycle  <= 32'd0;
            r_cnt_retire <= 32'd0;
            r_cnt_stall  <= 32'd0;
            r_cnt_flush  <= 32'd0;
        end else begin
            r_cnt_cycle <= r_cnt_cycle + 32'd1;
            if (retire) begin
                r_cnt_retire <= r_cnt_retire + 32'd1;
            end
            if (!id_en && !id_rst) begin
                r_cnt_stall <= r_cnt_stall + 32'd1;
            end
            if (id_rst && w_id_valid) begin
                r_cnt_flush <= r_cnt_flush + 32'd1;
            end
        end
    end

    assign cnt_cycle  = r_cnt_cycle;
    assign cnt_retire = r_cnt_retire;
    assign cnt_stall  = r_cnt_stall;
    assign cnt_flush  = r_cnt_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_tracker
//  Purpose  : Self-checking bench for pipe_stage_tracker. A stage-array
//             model predicts every output each cycle; directed sequences
//             add hand-computed expectations.
//  Config   : PIPE_PERF_CNT_EN - also exercises the counter bank.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_tracker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_rst = 0, id_rst = 0, exe_rst = 0, mem_rst = 0, wb_rst = 0;
    logic        if_en = 0, id_en = 0, exe_en = 0, mem_en = 0, wb_en = 0;
    logic [31:0] inst_if = 32'h0;
    logic [4:0]  id_regw_addr = 5'd0;
    logic        id_wb_wen = 0, id_is_branch = 0, id_mem_ren = 0;
    logic        if_valid, id_valid, exe_valid, mem_valid, wb_valid;
    logic [31:0] inst_id, inst_data_exe, inst_data_mem;
    logic [4:0]  regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic        wb_wen_exe, wb_wen_mem, wb_wen_wb;
    logic        is_branch_exe, is_branch_mem, is_load_exe, is_load_mem;
    logic        retire;
`ifdef PIPE_PERF_CNT_EN
    logic        perf_clr = 1'b0;
    logic [31:0] cnt_cycle, cnt_retire, cnt_stall, cnt_flush;
`endif

    pipe_stage_tracker dut (
        .clk(clk), .rst_n(rst_n),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst),
        .mem_rst(mem_rst), .wb_rst(wb_rst),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en),
        .mem_en(mem_en), .wb_en(wb_en),
        .inst_if(inst_if), .id_regw_addr(id_regw_addr),
        .id_wb_wen(id_wb_wen), .id_is_branch(id_is_branch),
        .id_mem_ren(id_mem_ren),
        .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid),
        .inst_id(inst_id), .inst_data_exe(inst_data_exe),
        .inst_data_mem(inst_data_mem),
        .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem),
        .regw_addr_wb(regw_addr_wb),
        .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem),
        .wb_wen_wb(wb_wen_wb),
        .is_branch_exe(is_branch_exe), .is_branch_mem(is_branch_mem),
        .is_load_exe(is_load_exe), .is_load_mem(is_load_mem),
        .retire(retire)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_clr(perf_clr), .cnt_cycle(cnt_cycle), .cnt_retire(cnt_retire),
        .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Model: five slots indexed IF..WB; each edge every slot either
    // empties, takes the contents of the slot before it, or keeps its own.
    // ------------------------------------------------------------------
    logic        m_valid [0:4];
    logic [31:0] m_inst  [0:4];
    logic [4:0]  m_addr  [0:4];
    logic        m_wen   [0:4];
    logic        m_br    [0:4];
    logic        m_ld    [0:4];
    logic [31:0] m_cyc = 0, m_ret = 0, m_stl = 0, m_fls = 0;

    initial begin
        for (int s = 0; s < 5; s++) begin
            m_valid[s] = 0; m_inst[s] = 0; m_addr[s] = 0;
            m_wen[s] = 0; m_br[s] = 0; m_ld[s] = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        logic st_rst [0:4];
        logic st_en  [0:4];
        st_rst = '{if_rst, id_rst, exe_rst, mem_rst, wb_rst};
        st_en  = '{if_en, id_en, exe_en, mem_en, wb_en};
        if (!rst_n) begin
            for (int s = 0; s < 5; s++) begin
                m_valid[s] <= 0; m_inst[s] <= 0; m_addr[s] <= 0;
                m_wen[s] <= 0; m_br[s] <= 0; m_ld[s] <= 0;
            end
            m_cyc <= 0; m_ret <= 0; m_stl <= 0; m_fls <= 0;
        end else begin
            if (if_rst) m_valid[0] <= 0;
            else if (if_en) m_valid[0] <= 1;
            for (int s = 1; s < 5; s++) begin
                if (st_rst[s]) begin
                    m_valid[s] <= 0; m_inst[s] <= 0; m_addr[s] <= 0;
                    m_wen[s] <= 0; m_br[s] <= 0; m_ld[s] <= 0;
                end else if (st_en[s]) begin
                    m_valid[s] <= m_valid[s-1];
                    if (s == 1) begin
                        m_inst[s] <= inst_if; m_addr[s] <= 0;
                        m_wen[s] <= 0; m_br[s] <= 0; m_ld[s] <= 0;
                    end else if (s == 2) begin
                        m_inst[s] <= m_inst[1]; m_addr[s] <= id_regw_addr;
                        m_wen[s] <= id_wb_wen; m_br[s] <= id_is_branch;
                        m_ld[s] <= id_mem_ren;
                    end else begin
                        m_inst[s] <= m_inst[s-1]; m_addr[s] <= m_addr[s-1];
                        m_wen[s] <= m_wen[s-1]; m_br[s] <= m_br[s-1];
                        m_ld[s] <= m_ld[s-1];
                    end
                end
            end
`ifdef PIPE_PERF_CNT_EN
            if (perf_clr) begin
                m_cyc <= 0; m_ret <= 0; m_stl <= 0; m_fls <= 0;
            end else begin
                m_cyc <= m_cyc + 1;
                m_ret <= m_ret + ((m_valid[4] && wb_en && !wb_rst) ? 1 : 0);
                m_stl <= m_stl + ((!id_en && !id_rst) ? 1 : 0);
                m_fls <= m_fls + ((id_rst && m_valid[1]) ? 1 : 0);
            end
`endif
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("if_valid",  {31'b0, if_valid},  {31'b0, m_valid[0]});
        chk("id_valid",  {31'b0, id_valid},  {31'b0, m_valid[1]});
        chk("exe_valid", {31'b0, exe_valid}, {31'b0, m_valid[2]});
        chk("mem_valid", {31'b0, mem_valid}, {31'b0, m_valid[3]});
        chk("wb_valid",  {31'b0, wb_valid},  {31'b0, m_valid[4]});
        chk("inst_id",   inst_id,       m_inst[1]);
        chk("inst_exe",  inst_data_exe, m_inst[2]);
        chk("inst_mem",  inst_data_mem, m_inst[3]);
        chk("addr_exe", {27'b0, regw_addr_exe}, {27'b0, m_valid[2] ? m_addr[2] : 5'd0});
        chk("addr_mem", {27'b0, regw_addr_mem}, {27'b0, m_valid[3] ? m_addr[3] : 5'd0});
        chk("addr_wb",  {27'b0, regw_addr_wb},  {27'b0, m_valid[4] ? m_addr[4] : 5'd0});
        chk("wen_exe", {31'b0, wb_wen_exe}, {31'b0, m_valid[2] & m_wen[2]});
        chk("wen_mem", {31'b0, wb_wen_mem}, {31'b0, m_valid[3] & m_wen[3]});
        chk("wen_wb",  {31'b0, wb_wen_wb},  {31'b0, m_valid[4] & m_wen[4]});
        chk("br_exe", {31'b0, is_branch_exe}, {31'b0, m_valid[2] & m_br[2]});
        chk("br_mem", {31'b0, is_branch_mem}, {31'b0, m_valid[3] & m_br[3]});
        chk("ld_exe", {31'b0, is_load_exe},   {31'b0, m_valid[2] & m_ld[2]});
        chk("ld_mem", {31'b0, is_load_mem},   {31'b0, m_valid[3] & m_ld[3]});
        chk("retire", {31'b0, retire}, {31'b0, m_valid[4] & wb_en & ~wb_rst});
`ifdef PIPE_PERF_CNT_EN
        chk("cnt_cycle",  cnt_cycle,  m_cyc);
        chk("cnt_retire", cnt_retire, m_ret);
        chk("cnt_stall",  cnt_stall,  m_stl);
        chk("cnt_flush",  cnt_flush,  m_fls);
`endif
    end

    // Advance one cycle; returns just after the falling edge.
    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic all_en(input logic v);
        if_en = v; id_en = v; exe_en = v; mem_en = v; wb_en = v;
    endtask

    initial begin
        // Reset state
        next(); next();
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_inst_id",  inst_id, 32'd0);
        chk("rst_retire",   {31'b0, retire}, 32'd0);

        // Free run with addi $1
        rst_n = 1; all_en(1);
        inst_if = 32'h2001_0005; id_regw_addr = 5'd1; id_wb_wen = 1;
        next();
        chk("fr_if_valid", {31'b0, if_valid}, 32'd1);
        chk("fr_id_valid0", {31'b0, id_valid}, 32'd0);
        next();
        chk("fr_id_valid1", {31'b0, id_valid}, 32'd1);
        chk("fr_inst_id", inst_id, 32'h2001_0005);
        next();
        chk("fr_addr_exe", {27'b0, regw_addr_exe}, 32'd1);
        chk("fr_wen_exe",  {31'b0, wb_wen_exe}, 32'd1);
        chk("fr_wen_mem0", {31'b0, wb_wen_mem}, 32'd0);
        next();
        chk("fr_wen_mem1", {31'b0, wb_wen_mem}, 32'd1);
        chk("fr_retire0",  {31'b0, retire}, 32'd0);
        next();
        chk("fr_retire1",  {31'b0, retire}, 32'd1);
        chk("fr_addr_wb",  {27'b0, regw_addr_wb}, 32'd1);

        // Mixed stream of loads and writes
        for (int i = 0; i < 6; i++) begin
            inst_if = 32'h8C00_0000 | i;
            id_regw_addr = 5'(i + 2);
            id_mem_ren = i[0];
            next();
        end

        // Load-use stall
        inst_if = 32'h1111_0001; id_regw_addr = 5'd3; id_mem_ren = 1;
        next();
        chk("st_inst_id0", inst_id, 32'h1111_0001);
        if_en = 0; id_en = 0; exe_rst = 1; inst_if = 32'h2222_0002;
        next();
        chk("st_inst_id1", inst_id, 32'h1111_0001);
        chk("st_exe_valid", {31'b0, exe_valid}, 32'd0);
        chk("st_wen_exe",   {31'b0, wb_wen_exe}, 32'd0);
        all_en(1); exe_rst = 0;
        next();
        chk("st_inst_exe", inst_data_exe, 32'h1111_0001);
        chk("st_exe_valid1", {31'b0, exe_valid}, 32'd1);
        chk("st_inst_id2", inst_id, 32'h2222_0002);

        // Branch then flush for two cycles (id_rst with id_en high)
        id_mem_ren = 0; id_is_branch = 1; inst_if = 32'h1000_0010;
        next();
        chk("br_exe1", {31'b0, is_branch_exe}, 32'd1);
        id_is_branch = 0; id_rst = 1; inst_if = 32'h2003_0007;
        next();
        chk("br_mem1", {31'b0, is_branch_mem}, 32'd1);
        chk("fl_id_valid", {31'b0, id_valid}, 32'd0);
        chk("fl_inst_id",  inst_id, 32'd0);
        next();
        chk("fl_exe_valid0", {31'b0, exe_valid}, 32'd0);
        id_rst = 0;
        next();
        chk("fl_exe_valid1", {31'b0, exe_valid}, 32'd0);
        chk("fl_id_valid1",  {31'b0, id_valid}, 32'd1);

        // Fill the pipe, then async reset mid-cycle
        for (int i = 0; i < 5; i++) begin
            inst_if = 32'h2004_0000 + i;
            next();
        end
        chk("ar_wb_full", {31'b0, wb_valid}, 32'd1);
        rst_n = 0;
        #1;
        chk("ar_id_valid",  {31'b0, id_valid},  32'd0);
        chk("ar_exe_valid", {31'b0, exe_valid}, 32'd0);
        chk("ar_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("ar_wb_valid",  {31'b0, wb_valid},  32'd0);
        chk("ar_wen_mem",   {31'b0, wb_wen_mem}, 32'd0);
        chk("ar_wen_wb",    {31'b0, wb_wen_wb},  32'd0);
        next();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            inst_if = 32'h2005_0000 + i;
            next();
        end
        chk("rf_wb_valid", {31'b0, wb_valid}, 32'd1);

`ifdef PIPE_PERF_CNT_EN
        perf_clr = 1;
        next();
        perf_clr = 0;
        for (int i = 0; i < 100; i++) begin
            id_en = (i == 10 || i == 40 || i == 70) ? 1'b0 : 1'b1;
            next();
        end
        id_en = 1;
        chk("pc_cycle100", cnt_cycle, 32'd100);
        chk("pc_stall3",   cnt_stall, 32'd3);
        perf_clr = 1;
        next();
        chk("pc_clr_cycle",  cnt_cycle,  32'd0);
        chk("pc_clr_retire", cnt_retire, 32'd0);
        perf_clr = 0;
        next();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_tracker.md
# pipe_stage_tracker

Datapath-side responder for the 5-stage MIPS pipeline control interface. Consumes the per-stage reset/enable strobes issued by the pipeline controller, carries each instruction's control metadata through the ID/EXE/MEM/WB pipeline registers, and returns the stage-valid flags and the EXE/MEM hazard feedback that the controller uses for forwarding, stall and branch-flush decisions. An optional performance-counter bank records cycles, retirements, stalls and flushes.

## Interface
- Parameters: none; all widths are fixed by the ISA.
- clk  in  1  main clock
- rst_n  in  1  asynchronous, active-low reset
- if_rst, id_rst, exe_rst, mem_rst, wb_rst  in  1 each  synchronous per-stage bubble insertion from the controller
- if_en, id_en, exe_en, mem_en, wb_en  in  1 each  per-stage advance enables
- inst_if  in  32  instruction fetched this cycle
- id_regw_addr  in  5  destination register decoded from inst_id
- id_wb_wen  in  1  decoded register-write enable
- id_is_branch  in  1  decoded jump/branch (pc_src != PC_NEXT)
- id_mem_ren  in  1  decoded load
- if_valid, id_valid, exe_valid, mem_valid, wb_valid  out  1 each  stage holds a real instruction
- inst_id  out  32  ID-stage instruction (to decoder)
- inst_data_exe, inst_data_mem  out  32  instruction in EXE / MEM
- regw_addr_exe, regw_addr_mem, regw_addr_wb  out  5  destination register per stage
- wb_wen_exe, wb_wen_mem, wb_wen_wb  out  1  valid-gated write enable
- is_branch_exe, is_branch_mem  out  1  valid-gated branch flag
- is_load_exe, is_load_mem  out  1  valid-gated load flag
- retire  out  1  pulse: instruction leaves WB this cycle
- perf_clr  in  1  synchronous clear of counters (PIPE_PERF_CNT_EN only)
- cnt_cycle, cnt_retire, cnt_stall, cnt_flush  out  32 each  counters (PIPE_PERF_CNT_EN only)

## Operation
- Each stage register (ID, EXE, MEM, WB) uses this priority: rst_n low -> cleared; else stage_rst -> valid=0, inst=NOP (32'h0), addr=0, all flags 0; else stage_en -> capture upstream valid and fields; else hold.
- IF valid: cleared by rst_n or if_rst; set to 1 when if_en is high and if_rst is low; held otherwise.
- ID captures inst_if and if_valid. EXE captures inst_id, id_valid, id_regw_addr, id_wb_wen, id_is_branch and id_mem_ren. MEM captures from EXE; WB captures from MEM.
- Every flag output is ANDed with its stage's valid flag, so a bubble never reports a write, branch or load.
- regw_addr_* outputs report 0 when the stage is invalid.
- retire = wb_valid & wb_en & ~wb_rst.
- Stall pattern (if_en = id_en = 0, exe_rst = 1): IF and ID hold their contents, and a bubble enters EXE on the next edge.
- Branch-flush pattern (id_rst = 1): ID becomes a bubble, IF keeps advancing, and downstream stages advance normally.
- Simultaneous stage_rst and stage_en: reset wins.
- rst_n asserted mid-operation: all state clears immediately, without waiting for a clock edge.

## Timing
- One-cycle latency per stage: an instruction on inst_if at edge N appears on inst_id after N, on inst_data_exe after N+1, on inst_data_mem after N+2, and in WB after N+3.
- All outputs are registered, except the valid-gating AND and retire, which are combinational from registers and strobes.
- Reset values: every valid = 0, inst outputs = 0, addresses = 0, flags = 0, retire = 0, counters = 0.
- The first if_valid = 1 appears one edge after rst_n deasserts, provided if_en = 1.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - cnt_cycle increments every cycle.
  - cnt_retire increments on retire.
  - cnt_stall increments when id_en = 0 and id_rst = 0.
  - cnt_flush increments when id_rst = 1 and id_valid = 1.
  - All counters wrap modulo 2^32.
  - perf_clr zeroes all counters on the next edge and takes priority over any increment in the same cycle.
- PIPE_PERF_CNT_EN undefined: perf_clr and the counter ports are absent, and no counter logic is built.

## Structure
- Shared header holds the NOP encoding, INST_LW/INST_SW opcodes and the stage index constants; this block includes it alongside the existing MIPS define header.
- One sub-module, pipe_stage_reg: a generic valid+payload register with rst/en priority, instantiated for ID, EXE, MEM and WB with per-stage payload width.

## Test plan
- Free run, all en = 1, inst_if = 0x20010005 (addi $1, ...) with id_regw_addr = 1 and id_wb_wen = 1 -> regw_addr_exe = 1 and wb_wen_exe = 1 at N+1; wb_wen_mem = 1 at N+2; retire = 1 at N+3.
- Load-use stall (if_en = id_en = 0, exe_rst = 1 for one cycle) -> inst_id is unchanged, exe_valid = 0, wb_wen_exe = 0, and the held instruction enters EXE one cycle later.
- Branch flush: id_is_branch = 1, then id_rst = 1 for 2 cycles -> is_branch_exe = 1 then is_branch_mem = 1; the two following slots have exe_valid = 0; cnt_flush += 2 when enabled.
- id_rst and id_en both high -> id_valid = 0 and inst_id = 0.
- rst_n pulled low while 4 instructions are in flight -> all valids and wb_wen_* drop to 0 without waiting for a clock edge; refill restarts cleanly.
- With PIPE_PERF_CNT_EN: 100 cycles including 3 stalls -> cnt_cycle = 100 and cnt_stall = 3; perf_clr alongside an increment -> counter reads 0.
